alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, handshaked successor to the core 8-bit ALU.
- Provides WIDTH-bit datapath, a 4-bit opcode space (original 3-bit encodings preserved), four flags, carry-chained add/sub, left/rotate shifts, and an iterative shift-add multiplier.
- Sits between decode and the register file.
- Decode issues via execute/ready; writeback consumes out on done.

Parameters:
- WIDTH, 8, datapath width; power of two, >= 4.
- SHW, $clog2(WIDTH), shift-amount bits taken from in_immediate (derived, not overridden).

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_immediate  input  WIDTH  shift amount source (low SHW bits used)
- control  input  4  opcode
- execute  input  1  issue request
- ready  output  1  high when an issue will be accepted
- done  output  1  one-cycle pulse: out/flags updated this cycle
- out  output  WIDTH  result register
- zf, cf, nf, vf  output  1 each  zero, carry/borrow, negative, signed-overflow flags

Behaviour:
- Reset (async): out=0, zf=cf=nf=vf=0, done=0, ready=1, FSM to IDLE; internal operand/counter registers cleared.
- Reset asserted mid-operation aborts it; no done is produced for the aborted operation.
- Accept: execute && ready at edge N latches control, in_a (alpha), in_b (beta), in_immediate. ready drops at N.
- Execute while ready=0 is ignored (not queued).
- FSM states:
  - IDLE -> CALC on accept of a non-multiply opcode.
  - IDLE -> MUL on accept of a multiply opcode.
  - CALC -> IDLE after one cycle.
  - MUL -> IDLE when counter reaches WIDTH.
- Single-cycle latency: out/flags written at edge N+1, done=1 during cycle N+1..N+2, ready=1 again after N+1. Back-to-back issue gives one op every 2 cycles.
- Multiply latency: WIDTH iterations, result written at edge N+WIDTH; done follows the same pulse rule.
- Opcodes:
  - 0 NAND, 1 AND, 2 XOR, 8 OR: out=result; zf, nf updated; cf, vf unchanged.
  - 3 SHR: logical right by k=imm[SHW-1:0]. 9 SHL: logical left by k.
    - k>0: cf = last bit shifted out (SHR alpha[k-1], SHL alpha[WIDTH-k]).
    - k=0: out=alpha, cf unchanged.
    - zf, nf updated; vf unchanged.
  - 10 ROR: rotate right by k; zf, nf updated; cf, vf unchanged.
  - 4 MOV: out=beta; no flag change.
  - 6 ADD, 11 ADC (+cf): WIDTH+1-bit sum; cf=carry out, vf=signed overflow, zf, nf from result.
  - 7 SUB, 12 SBB (-cf): WIDTH+1-bit difference; cf=borrow (difference MSB), vf, zf, nf as for add.
  - 5 CMP: flags as SUB; out unchanged.
  - 13 MUL: out=low WIDTH bits of unsigned product. 14 MULH: out=high WIDTH bits.
    - Both: zf from the written half; cf=vf=(high half != 0); nf from written half MSB.
  - 15 NOP: nothing changes except done pulses.
- ADC/SBB use cf as it stands at accept time.
- All arithmetic wraps modulo 2^WIDTH.

Decomposition:
- Package alu_seq_pkg:
  - opcode localparams (OP_NAND..OP_NOP, 4-bit);
  - FSM state encoding (ST_IDLE, ST_CALC, ST_MUL);
  - helper function for signed-overflow detection.
- Sub-module alu_seq_mul:
  - iterative unsigned shift-add multiplier;
  - ports clk, reset, start, a, b, busy, product[2*WIDTH-1:0];
  - exactly WIDTH cycles from start to product valid;
  - instanced once, reset shared.

Test Plan (WIDTH=8 unless stated):
- Reset mid-MUL: issue 13, a=0x0F, b=0x0F, assert reset at cycle 3 -> out=0, flags 0, ready=1, no done pulse; then ADD 1+1 -> out=0x02.
- ADD/ADC chain: ADD 0xFF+0x01 -> out=0x00, zf=1, cf=1, vf=0; then ADC 0x00+0x00 -> out=0x01, cf=0, zf=0.
- SUB/CMP: SUB 0x05-0x07 -> out=0xFE, cf=1, nf=1, zf=0; CMP 0x80-0x01 -> out unchanged, vf=1, cf=0.
- Shifts: SHR 0x81 by 1 -> out=0x40, cf=1; SHL 0x81 by 1 -> out=0x02, cf=1; SHR by 0 -> out=alpha, cf unchanged; ROR 0x01 by 1 -> 0x80, nf=1.
- Multiply latency: MUL 0x10*0x10 -> out=0x00, done exactly 8 cycles after accept edge, cf=1, zf=1; MULH same operands -> out=0x01, zf=0.
- Handshake: pulse execute every cycle with distinct operands -> only the ops seen with ready=1 produce done; WIDTH=16 ADD 0xFFFF+1 -> out=0x0000, cf=1.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared opcode, state and helper definitions for the sequenced ALU.
// Opcodes 0..7 keep the encodings of the original 8-bit ALU.
package alu_seq_pkg;

    localparam logic [3:0] OP_NAND = 4'd0;
    localparam logic [3:0] OP_AND  = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd2;
    localparam logic [3:0] OP_SHR  = 4'd3;
    localparam logic [3:0] OP_MOV  = 4'd4;
    localparam logic [3:0] OP_CMP  = 4'd5;
    localparam logic [3:0] OP_ADD  = 4'd6;
    localparam logic [3:0] OP_SUB  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_SHL  = 4'd9;
    localparam logic [3:0] OP_ROR  = 4'd10;
    localparam logic [3:0] OP_ADC  = 4'd11;
    localparam logic [3:0] OP_SBB  = 4'd12;
    localparam logic [3:0] OP_MUL  = 4'd13;
    localparam logic [3:0] OP_MULH = 4'd14;
    localparam logic [3:0] OP_NOP  = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_MUL  = 2'd2
    } state_t;

    // Two's-complement overflow from operand and result sign bits.
    function automatic logic signed_ovf(
        input logic a_msb,
        input logic b_msb,
        input logic r_msb,
        input logic sub
    );
        if (sub)
            return (a_msb != b_msb) && (r_msb != a_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_MULH);
    endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle.
// Bit 0 is folded in on the start edge so the product settles WIDTH cycles on.
module alu_seq_mul
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;

    // Load operands with the first partial product, then accumulate one bit per cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            product <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
        end else if (start) begin
            product <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
            mcand   <= {{(WIDTH-1){1'b0}}, a, 1'b0};
            mplier  <= b >> 1;
            cnt     <= CW'(1);
            busy    <= 1'b1;
        end else if (busy) begin
            if (mplier[0])
                product <= product + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            busy   <= (cnt + 1'b1) != LAST;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked, parametrised ALU: one-cycle ops through CALC, multiplies through MUL.
// Operands are latched on accept; out and flags are registered and qualified by done.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_immediate,
    input  logic [3:0]       control,
    input  logic             execute,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             zf,
    output logic             cf,
    output logic             nf,
    output logic             vf
);

    localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH);

    state_t             state;
    logic [3:0]         op;
    logic [WIDTH-1:0]   alpha;
    logic [WIDTH-1:0]   beta;
    logic [SHW-1:0]     k;
    logic [SHW:0]       cnt;

    logic               accept;
    logic               mul_start;
    logic               mul_busy;
    logic [2*WIDTH-1:0] product;

    logic [WIDTH-1:0]   n_out;
    logic               n_zf;
    logic               n_cf;
    logic               n_nf;
    logic               n_vf;
    logic               upd_zn;
    logic [WIDTH-1:0]   zn_src;
    logic [WIDTH:0]     wide;
    logic               cin;
    logic [SHW-1:0]     km1;
    logic [SHW-1:0]     kneg;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   half;
    logic [WIDTH-1:0]   ror_res;
    logic [WIDTH-1:0]   unused_rot;
    logic               unused_imm;

    assign accept     = execute && ready;
    assign mul_start  = accept && is_mul_op(control);
    assign unused_imm = ^in_immediate[WIDTH-1:SHW];
    assign {unused_rot, ror_res} = {alpha, alpha} >> k;

    alu_seq_mul #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk    (clk),
        .reset  (reset),
        .start  (mul_start),
        .a      (in_a),
        .b      (in_b),
        .busy   (mul_busy),
        .product(product)
    );

    // Next result and flags for the latched opcode; unchanged flags hold.
    always_comb begin
        n_out  = out;
        n_zf   = zf;
        n_cf   = cf;
        n_nf   = nf;
        n_vf   = vf;
        upd_zn = 1'b0;
        zn_src = '0;
        wide   = '0;
        cin    = 1'b0;
        km1    = k - 1'b1;
        kneg   = '0 - k;
        hi     = product[2*WIDTH-1:WIDTH];
        half   = (op == OP_MULH) ? hi : product[WIDTH-1:0];
        unique case (op)
            OP_NAND: begin
                n_out  = ~(alpha & beta);
                upd_zn = 1'b1;
            end
            OP_AND: begin
                n_out  = alpha & beta;
                upd_zn = 1'b1;
            end
            OP_XOR: begin
                n_out  = alpha ^ beta;
                upd_zn = 1'b1;
            end
            OP_OR: begin
                n_out  = alpha | beta;
                upd_zn = 1'b1;
            end
            OP_SHR: begin
                n_out  = alpha >> k;
                upd_zn = 1'b1;
                if (k != '0)
                    n_cf = alpha[km1];
            end
            OP_SHL: begin
                n_out  = alpha << k;
                upd_zn = 1'b1;
                if (k != '0)
                    n_cf = alpha[kneg];
            end
            OP_ROR: begin
                n_out  = ror_res;
                upd_zn = 1'b1;
            end
            OP_MOV: begin
                n_out = beta;
            end
            OP_ADD, OP_ADC: begin
                cin    = (op == OP_ADC) && cf;
                wide   = {1'b0, alpha} + {1'b0, beta}
                       + {{WIDTH{1'b0}}, cin};
                n_out  = wide[WIDTH-1:0];
                n_cf   = wide[WIDTH];
                n_vf   = signed_ovf(alpha[WIDTH-1], beta[WIDTH-1],
                                    wide[WIDTH-1], 1'b0);
                upd_zn = 1'b1;
            end
            OP_SUB, OP_SBB, OP_CMP: begin
                cin    = (op == OP_SBB) && cf;
                wide   = {1'b0, alpha} - {1'b0, beta}
                       - {{WIDTH{1'b0}}, cin};
                if (op != OP_CMP)
                    n_out = wide[WIDTH-1:0];
                n_cf   = wide[WIDTH];
                n_vf   = signed_ovf(alpha[WIDTH-1], beta[WIDTH-1],
                                    wide[WIDTH-1], 1'b1);
                upd_zn = 1'b1;
            end
            OP_MUL, OP_MULH: begin
                n_out  = half;
                n_cf   = |hi;
                n_vf   = |hi;
                upd_zn = 1'b1;
            end
            default: begin
            end
        endcase
        zn_src = (op == OP_CMP) ? wide[WIDTH-1:0] : n_out;
        if (upd_zn) begin
            n_zf = (zn_src == '0);
            n_nf = zn_src[WIDTH-1];
        end
    end

    // Issue/complete FSM with registered handshake, result and flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            op    <= OP_NOP;
            alpha <= '0;
            beta  <= '0;
            k     <= '0;
            cnt   <= '0;
            ready <= 1'b1;
            done  <= 1'b0;
            out   <= '0;
            zf    <= 1'b0;
            cf    <= 1'b0;
            nf    <= 1'b0;
            vf    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op    <= control;
                        alpha <= in_a;
                        beta  <= in_b;
                        k     <= in_immediate[SHW-1:0];
                        cnt   <= (SHW+1)'(1);
                        ready <= 1'b0;
                        state <= is_mul_op(control) ? ST_MUL : ST_CALC;
                    end
                end
                ST_CALC: begin
                    out   <= n_out;
                    zf    <= n_zf;
                    cf    <= n_cf;
                    nf    <= n_nf;
                    vf    <= n_vf;
                    done  <= 1'b1;
                    ready <= 1'b1;
                    state <= ST_IDLE;
                end
                ST_MUL: begin
                    if (cnt == CNT_LAST && !mul_busy) begin
                        out   <= n_out;
                        zf    <= n_zf;
                        cf    <= n_cf;
                        nf    <= n_nf;
                        vf    <= n_vf;
                        done  <= 1'b1;
                        ready <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed plan, handshake and random ops
// compared against an integer-arithmetic reference model.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  a, b, imm;
    logic [3:0]  ctl;
    logic        exe;
    logic        ready, done, zf, cf, nf, vf;
    logic [7:0]  out;

    logic [15:0] a16, b16, imm16;
    logic [3:0]  ctl16;
    logic        exe16;
    logic        ready16, done16, zf16, cf16, nf16, vf16;
    logic [15:0] out16;

    int total = 0;
    int bad = 0;

    int m_out, m_z, m_c, m_n, m_v;
    int exp_q[$];

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(8)) dut (
        .clk(clk), .reset(rst), .in_a(a), .in_b(b),
        .in_immediate(imm), .control(ctl), .execute(exe),
        .ready(ready), .done(done), .out(out),
        .zf(zf), .cf(cf), .nf(nf), .vf(vf)
    );

    alu_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(rst), .in_a(a16), .in_b(b16),
        .in_immediate(imm16), .control(ctl16), .execute(exe16),
        .ready(ready16), .done(done16), .out(out16),
        .zf(zf16), .cf(cf16), .nf(nf16), .vf(vf16)
    );

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int pack_model();
        return (m_out << 4) | (m_z << 3) | (m_c << 2) | (m_n << 1) | m_v;
    endfunction

    function automatic logic [31:0] pack_dut();
        return 32'({out, zf, cf, nf, vf});
    endfunction

    task automatic set_zn(input int r);
        m_z = (r == 0) ? 1 : 0;
        m_n = (r >= 128) ? 1 : 0;
    endtask

    // Reference: what each opcode means in plain integer arithmetic.
    task automatic model(input int op, input int x, input int y, input int sh);
        int kk, sx, sy, cin, s, ss, r, p;
        kk  = sh % 8;
        sx  = (x >= 128) ? x - 256 : x;
        sy  = (y >= 128) ? y - 256 : y;
        cin = (op == 11 || op == 12) ? m_c : 0;
        case (op)
            0:  begin m_out = 255 - (x & y); set_zn(m_out); end
            1:  begin m_out = x & y; set_zn(m_out); end
            2:  begin m_out = x ^ y; set_zn(m_out); end
            8:  begin m_out = x | y; set_zn(m_out); end
            3: begin
                m_out = x / (1 << kk);
                if (kk > 0) m_c = (x / (1 << (kk - 1))) % 2;
                set_zn(m_out);
            end
            9: begin
                m_out = (x * (1 << kk)) % 256;
                if (kk > 0) m_c = (x * (1 << kk) / 256) % 2;
                set_zn(m_out);
            end
            10: begin
                m_out = (x / (1 << kk) + x * (1 << (8 - kk))) % 256;
                set_zn(m_out);
            end
            4:  m_out = y;
            6, 11: begin
                s = x + y + cin;
                ss = sx + sy + cin;
                m_out = s % 256;
                m_c = (s > 255) ? 1 : 0;
                m_v = (ss > 127 || ss < -128) ? 1 : 0;
                set_zn(m_out);
            end
            5, 7, 12: begin
                s = x - y - cin;
                ss = sx - sy - cin;
                r = (s + 512) % 256;
                m_c = (s < 0) ? 1 : 0;
                m_v = (ss > 127 || ss < -128) ? 1 : 0;
                if (op != 5) m_out = r;
                set_zn(r);
            end
            13, 14: begin
                p = x * y;
                m_out = (op == 13) ? p % 256 : p / 256;
                m_c = (p >= 256) ? 1 : 0;
                m_v = m_c;
                set_zn(m_out);
            end
            default: ;
        endcase
    endtask

    task automatic issue(input int op, input int x, input int y,
                         input int sh, input string tag);
        int w, lat;
        w = 0;
        @(negedge clk);
        while (!ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk({tag, ":ready_in"}, 32'(ready), 32'd1);
        ctl = 4'(op);
        a = 8'(x);
        b = 8'(y);
        imm = 8'(sh);
        exe = 1'b1;
        @(negedge clk);
        exe = 1'b0;
        chk({tag, ":ready_drop"}, 32'(ready), 32'd0);
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        model(op, x, y, sh);
        chk({tag, ":latency"}, 32'(lat), (op == 13 || op == 14) ? 32'd8 : 32'd1);
        chk({tag, ":result"}, pack_dut(), 32'(pack_model()));
        @(negedge clk);
        chk({tag, ":done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int nacc, ndone, dcnt, w, op, x, y;
        rst = 1'b1;
        exe = 1'b0; ctl = '0; a = '0; b = '0; imm = '0;
        exe16 = 1'b0; ctl16 = '0; a16 = '0; b16 = '0; imm16 = '0;
        m_out = 0; m_z = 0; m_c = 0; m_n = 0; m_v = 0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_flags", pack_dut(), 32'd0);
        chk("reset_ready", 32'(ready), 32'd1);
        chk("reset_done", 32'(done), 32'd0);
        rst = 1'b0;

        // Reset in the middle of a multiply
        issue(6, 3, 4, 0, "pre_add");
        chk("pre_add_out", 32'(out), 32'h07);
        @(negedge clk);
        ctl = 4'd13; a = 8'h0F; b = 8'h0F; exe = 1'b1;
        @(negedge clk);
        exe = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midmul_out", pack_dut(), 32'd0);
        chk("midmul_ready", 32'(ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        m_out = 0; m_z = 0; m_c = 0; m_n = 0; m_v = 0;
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("midmul_no_done", 32'(dcnt), 32'd0);
        issue(6, 1, 1, 0, "post_rst_add");
        chk("post_rst_add_out", 32'(out), 32'h02);

        // Directed plan with fixed expectations
        issue(6, 8'hFF, 8'h01, 0, "add_ff_1");
        chk("add_ff_1_k", pack_dut(), {20'd0, 8'h00, 4'b1100});
        issue(11, 0, 0, 0, "adc_0_0");
        chk("adc_0_0_k", pack_dut(), {20'd0, 8'h01, 4'b0000});
        issue(7, 5, 7, 0, "sub_5_7");
        chk("sub_5_7_k", pack_dut(), {20'd0, 8'hFE, 4'b0110});
        issue(5, 8'h80, 8'h01, 0, "cmp_80_1");
        chk("cmp_80_1_k", pack_dut(), {20'd0, 8'hFE, 4'b0001});
        issue(3, 8'h81, 0, 1, "shr_81_1");
        chk("shr_81_1_k", pack_dut(), {20'd0, 8'h40, 4'b0101});
        issue(9, 8'h81, 0, 1, "shl_81_1");
        chk("shl_81_1_k", pack_dut(), {20'd0, 8'h02, 4'b0101});
        issue(3, 8'h35, 0, 8'hF8, "shr_by_0");
        chk("shr_by_0_k", pack_dut(), {20'd0, 8'h35, 4'b0101});
        issue(10, 8'h01, 0, 1, "ror_1_1");
        chk("ror_1_1_k", pack_dut(), {20'd0, 8'h80, 4'b0111});
        issue(13, 8'h10, 8'h10, 0, "mul_10_10");
        chk("mul_10_10_k", pack_dut(), {20'd0, 8'h00, 4'b1101});
        issue(14, 8'h10, 8'h10, 0, "mulh_10_10");
        chk("mulh_10_10_k", pack_dut(), {20'd0, 8'h01, 4'b0101});
        issue(15, 8'h12, 8'h34, 0, "nop");
        chk("nop_k", pack_dut(), {20'd0, 8'h01, 4'b0101});

        // Execute held high every cycle: only ready cycles are taken
        nacc = 0;
        ndone = 0;
        @(negedge clk);
        for (int i = 0; i < 14; i++) begin
            if (done) begin
                ndone++;
                if (exp_q.size() > 0)
                    chk("hs_result", pack_dut(), 32'(exp_q.pop_front()));
                else
                    chk("hs_extra_done", 32'd1, 32'd0);
            end
            op = $urandom_range(0, 12);
            x = $urandom_range(0, 255);
            y = $urandom_range(0, 255);
            ctl = 4'(op); a = 8'(x); b = 8'(y); imm = 8'(i);
            exe = 1'b1;
            if (ready) begin
                nacc++;
                model(op, x, y, i);
                exp_q.push_back(pack_model());
            end
            @(negedge clk);
        end
        exe = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (done) begin
                ndone++;
                if (exp_q.size() > 0)
                    chk("hs_result", pack_dut(), 32'(exp_q.pop_front()));
                else
                    chk("hs_extra_done", 32'd1, 32'd0);
            end
            @(negedge clk);
        end
        chk("hs_accepts", 32'(nacc), 32'd7);
        chk("hs_dones", 32'(ndone), 32'(nacc));

        // Random operations against the reference model
        for (int i = 0; i < 40; i++) begin
            issue($urandom_range(0, 15), $urandom_range(0, 255),
                  $urandom_range(0, 255), $urandom_range(0, 255), "rand");
        end

        // Wider datapath carry out
        @(negedge clk);
        ctl16 = 4'd6; a16 = 16'hFFFF; b16 = 16'h0001; exe16 = 1'b1;
        @(negedge clk);
        exe16 = 1'b0;
        w = 0;
        while (!done16 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("w16_latency", 32'(w), 32'd1);
        chk("w16_add", 32'({out16, zf16, cf16, nf16, vf16}),
            {12'd0, 16'h0000, 4'b1100});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
